// File: rtl/dpi_pkg.sv
// Shared types and sizing for the regex-matcher stream feeder.
package dpi_pkg;

    localparam int unsigned KEY_W       = 16;
    localparam int unsigned SID_W       = 6;
    localparam int unsigned NUM_STREAMS = 2 ** SID_W;
    localparam int unsigned NUM_REGEX   = 8;
    // Both gaps must be at least 2 and 1 respectively.
    localparam int unsigned LOAD_GAP    = 2;
    localparam int unsigned EOP_GAP     = 2;
    localparam int unsigned DROP_W      = 16;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        LOAD,
        GAP,
        STREAM,
        DRAIN,
        EOP,
        DROP
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [KEY_W-1:0] key;
    } stream_entry_t;

endpackage

// File: rtl/dpi_stream_feeder_if.sv
// Packet ingress and matcher-side buses of the stream feeder.
interface dpi_pkt_if;
    logic [7:0]                 data;
    logic [dpi_pkg::KEY_W-1:0]  key;
    logic                       sop;
    logic                       eop;
    logic                       vld;
    logic                       rdy;

    modport master (output data, key, sop, eop, vld, input rdy);
    modport slave  (input data, key, sop, eop, vld, output rdy);
endinterface

interface dpi_match_if;
    logic [7:0]                     char_in;
    logic                           char_in_vld;
    logic                           load_state;
    logic                           new_stream_id;
    logic [dpi_pkg::SID_W-1:0]      stream_id;
    logic [dpi_pkg::NUM_REGEX-1:0]  enable;
    logic                           eop;

    modport master (output char_in, char_in_vld, load_state, new_stream_id, stream_id, enable, eop);
    modport slave  (input  char_in, char_in_vld, load_state, new_stream_id, stream_id, enable, eop);
endinterface

// File: rtl/dpi_stream_table.sv
// Flow-key to stream-id CAM: parallel lookup, append-only allocation, bulk flush.
module dpi_stream_table
    import dpi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] lookup_key,
    input  logic             alloc,
    input  logic             flush,
    output logic             hit,
    output logic [SID_W-1:0] hit_idx,
    output logic             full,
    output logic [SID_W:0]   count
);

    stream_entry_t   tbl_q [NUM_STREAMS];
    stream_entry_t   tbl_d [NUM_STREAMS];
    logic [SID_W:0]  count_q;
    logic [SID_W:0]  count_d;

    assign full  = (count_q == (SID_W+1)'(NUM_STREAMS));
    assign count = count_q;

    // Lowest matching index wins; keys are unique so this only fixes priority.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
            if (!hit && tbl_q[i].valid && (tbl_q[i].key == lookup_key)) begin
                hit     = 1'b1;
                hit_idx = SID_W'(i);
            end
        end
    end

    always_comb begin
        tbl_d   = tbl_q;
        count_d = count_q;
        if (flush) begin
            for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
                tbl_d[i].valid = 1'b0;
            end
            count_d = '0;
        end else if (alloc && !full) begin
            tbl_d[count_q[SID_W-1:0]] = '{valid: 1'b1, key: lookup_key};
            count_d = count_q + (SID_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
                tbl_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            tbl_q   <= tbl_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dpi_stream_feeder.sv
// Maps packet flow keys to stream ids and sequences restore / payload / eop
// towards the shared regex matcher bank.
module dpi_stream_feeder
    import dpi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    dpi_pkt_if.slave             pkt,
    dpi_match_if.master          mtch,
    input  logic [NUM_REGEX-1:0] cfg_enable_mask,
    input  logic                 cfg_flush,
    output logic [SID_W:0]       stream_count,
    output logic [DROP_W-1:0]    drop_count,
    output logic                 err_nosop
);

    state_e                state_q, state_d;
    logic [KEY_W-1:0]      key_q, key_d;
    logic [SID_W-1:0]      sid_q, sid_d;
    logic [NUM_REGEX-1:0]  en_q, en_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            char_q, char_d;
    logic                  char_vld_q, char_vld_d;
    logic                  load_q, load_d;
    logic                  nsid_q, nsid_d;
    logic                  eop_q, eop_d;
    logic [DROP_W-1:0]     drop_q, drop_d;
    logic                  err_q, err_d;

    logic                  pkt_rdy_c;
    logic                  flush_c;
    logic                  alloc_c;
    logic                  last_gap_c;
    logic                  stream_en_c;
    logic                  tbl_hit;
    logic [SID_W-1:0]      tbl_hit_idx;
    logic                  tbl_full;

    dpi_stream_table u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_key (key_q),
        .alloc      (alloc_c),
        .flush      (flush_c),
        .hit        (tbl_hit),
        .hit_idx    (tbl_hit_idx),
        .full       (tbl_full),
        .count      (stream_count)
    );

    // The final GAP cycle already accepts a beat so the first char_in_vld
    // lands exactly LOAD_GAP cycles after load_state.
    assign last_gap_c  = (cnt_q == CNT_W'(LOAD_GAP - 2));
    assign stream_en_c = (state_q == STREAM) || ((state_q == GAP) && last_gap_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!cfg_flush && pkt.vld && pkt.sop) state_d = LOOKUP;
            end
            LOOKUP: state_d = (tbl_hit || !tbl_full) ? LOAD : DROP;
            LOAD:   state_d = GAP;
            GAP: begin
                if (last_gap_c) state_d = (pkt.vld && pkt.eop) ? DRAIN : STREAM;
            end
            STREAM: begin
                if (pkt.vld && pkt.eop) state_d = DRAIN;
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(EOP_GAP - 1)) state_d = EOP;
            end
            EOP:  state_d = IDLE;
            DROP: begin
                if (pkt.vld && pkt.eop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pkt_rdy_c  = 1'b0;
        flush_c    = 1'b0;
        alloc_c    = 1'b0;
        key_d      = key_q;
        sid_d      = sid_q;
        en_d       = en_q;
        cnt_d      = cnt_q;
        char_d     = char_q;
        char_vld_d = 1'b0;
        drop_d     = drop_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                pkt_rdy_c = pkt.vld && !pkt.sop;
                err_d     = pkt.vld && !pkt.sop;
                flush_c   = cfg_flush;
                if (!cfg_flush && pkt.vld && pkt.sop) key_d = pkt.key;
            end
            LOOKUP: begin
                cnt_d = '0;
                if (tbl_hit) begin
                    sid_d = tbl_hit_idx;
                    en_d  = cfg_enable_mask;
                end else if (!tbl_full) begin
                    alloc_c = 1'b1;
                    sid_d   = stream_count[SID_W-1:0];
                    en_d    = cfg_enable_mask;
                end
            end
            LOAD: cnt_d = '0;
            GAP: begin
                pkt_rdy_c = last_gap_c;
                cnt_d     = last_gap_c ? '0 : cnt_q + CNT_W'(1);
            end
            STREAM: begin
                pkt_rdy_c = 1'b1;
                cnt_d     = '0;
            end
            DRAIN: cnt_d = cnt_q + CNT_W'(1);
            DROP: begin
                pkt_rdy_c = 1'b1;
                if (pkt.vld && pkt.eop && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
            end
            default: ;
        endcase
        if (stream_en_c) begin
            char_vld_d = pkt.vld;
            if (pkt.vld) char_d = pkt.data;
        end
    end

    // Pulses are registered off the next state so they coincide with LOAD / EOP.
    assign load_d = (state_d == LOAD);
    assign nsid_d = alloc_c;
    assign eop_d  = (state_d == EOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q      <= '0;
            sid_q      <= '0;
            en_q       <= '0;
            cnt_q      <= '0;
            char_q     <= '0;
            char_vld_q <= 1'b0;
            load_q     <= 1'b0;
            nsid_q     <= 1'b0;
            eop_q      <= 1'b0;
            drop_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            key_q      <= key_d;
            sid_q      <= sid_d;
            en_q       <= en_d;
            cnt_q      <= cnt_d;
            char_q     <= char_d;
            char_vld_q <= char_vld_d;
            load_q     <= load_d;
            nsid_q     <= nsid_d;
            eop_q      <= eop_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    assign pkt.rdy            = pkt_rdy_c;
    assign mtch.char_in       = char_q;
    assign mtch.char_in_vld   = char_vld_q;
    assign mtch.load_state    = load_q;
    assign mtch.new_stream_id = nsid_q;
    assign mtch.stream_id     = sid_q;
    assign mtch.enable        = en_q;
    assign mtch.eop           = eop_q;
    assign drop_count         = drop_q;
    assign err_nosop          = err_q;

endmodule

// File: tb/tb_dpi_stream_feeder.sv
// Self-checking bench for dpi_stream_feeder: packet vectors plus an event scoreboard.
module tb_dpi_stream_feeder;
    import dpi_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REGEX-1:0] cfg_enable_mask;
    logic                 cfg_flush;
    logic [SID_W:0]       stream_count;
    logic [DROP_W-1:0]    drop_count;
    logic                 err_nosop;

    dpi_pkt_if   pif ();
    dpi_match_if mif ();

    dpi_stream_feeder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pkt             (pif),
        .mtch            (mif),
        .cfg_enable_mask (cfg_enable_mask),
        .cfg_flush       (cfg_flush),
        .stream_count    (stream_count),
        .drop_count      (drop_count),
        .err_nosop       (err_nosop)
    );

    always #5 clk = ~clk;

    // kind: 0 load_state, 1 char_in_vld, 2 eop, 3 err_nosop; delta < 0 = don't care
    typedef struct {
        int         kind;
        logic [5:0] sid;
        logic       nsid;
        logic [7:0] en;
        logic [7:0] data;
        int         delta;
    } evt_t;

    typedef struct {
        logic [15:0] key;
        int          len;
        logic [7:0]  mask;
        bit          drop;
        bit          nsid;
        logic [5:0]  sid;
        bit          bub;
        bit          chg;
        bit          flush;
        int          cnt;
        int          drops;
    } vec_t;

    evt_t expq[$];
    vec_t vecs[9];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   acc_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push(input int kind, input logic [5:0] sid, input logic nsid,
                                 input logic [7:0] en, input logic [7:0] data, input int delta);
        evt_t e;
        e.kind = kind; e.sid = sid; e.nsid = nsid; e.en = en; e.data = data; e.delta = delta;
        expq.push_back(e);
    endfunction

    task automatic got(input int kind);
        evt_t e;
        int   d;
        bit   bad;
        d = cyc - last_cyc;
        last_cyc = cyc;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
            return;
        end
        e = expq.pop_front();
        bad = (e.kind != kind) || (e.delta >= 0 && d != e.delta);
        if (kind != 3 && (mif.stream_id !== e.sid || mif.enable !== e.en)) bad = 1'b1;
        if (kind == 0 && mif.new_stream_id !== e.nsid) bad = 1'b1;
        if (kind == 1 && mif.char_in !== e.data) bad = 1'b1;
        if (bad) begin
            errors++;
            $display("FAIL event@%0d: got kind=%0d sid=%0d en=%h nsid=%b data=%h delta=%0d expected kind=%0d sid=%0d en=%h nsid=%b data=%h delta=%0d",
                     cyc, kind, mif.stream_id, mif.enable, mif.new_stream_id, mif.char_in, d,
                     e.kind, e.sid, e.en, e.nsid, e.data, e.delta);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pif.vld && pif.rdy) acc_cnt++;
            if (mif.load_state)     got(0);
            if (mif.char_in_vld)    got(1);
            if (mif.eop)            got(2);
            if (err_nosop)          got(3);
        end
    end

    task automatic idle(input int n);
        pif.vld = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic [15:0] k, input logic sop, input logic eop);
        bit acc = 1'b0;
        pif.data = d; pif.key = k; pif.sop = sop; pif.eop = eop; pif.vld = 1'b1;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = pif.rdy;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: got pkt_rdy=0 for 100 cycles expected acceptance");
        end
        pif.vld = 1'b0; pif.sop = 1'b0; pif.eop = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int         a0;
        logic [7:0] b;
        if (!v.drop) begin
            push(0, v.sid, v.nsid, v.mask, 8'h00, -1);
            for (int j = 0; j < v.len; j++) begin
                b = v.key[7:0] + 8'(j);
                push(1, v.sid, 1'b0, v.mask, b, (j == 0) ? int'(LOAD_GAP) : (v.bub ? 2 : 1));
            end
            push(2, v.sid, 1'b0, v.mask, 8'h00, int'(EOP_GAP));
        end
        cfg_enable_mask = v.mask;
        a0 = acc_cnt;
        for (int j = 0; j < v.len; j++) begin
            if (v.bub && j > 0) idle(1);
            b = v.key[7:0] + 8'(j);
            drive_beat(b, v.key, j == 0, j == v.len - 1);
            if (j == 0) begin
                if (v.chg)   cfg_enable_mask = ~v.mask;
                if (v.flush) cfg_flush = 1'b1;
            end
        end
        idle(8);
        if (v.drop) check({tag, "_drop_beats"}, 32'(acc_cnt - a0), 32'(v.len));
        if (v.flush) begin
            cfg_flush = 1'b0;
            idle(2);
        end
        check({tag, "_events_left"}, 32'(expq.size()), 32'd0);
        check({tag, "_stream_count"}, 32'(stream_count), 32'(v.cnt));
        check({tag, "_drop_count"}, 32'(drop_count), 32'(v.drops));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish within time limit expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t fv;
        //          key       len mask  drop nsid sid   bub chg flush cnt drops
        vecs[0] = '{16'h1234, 5, 8'hA5, 0, 1, 6'd0, 0, 0, 0, 1,  0};
        vecs[1] = '{16'h1234, 3, 8'h0F, 0, 0, 6'd0, 0, 0, 0, 1,  0};
        vecs[2] = '{16'hBEEF, 4, 8'hF0, 0, 1, 6'd1, 0, 0, 0, 2,  0};
        vecs[3] = '{16'h7777, 3, 8'hFF, 1, 0, 6'd0, 0, 0, 0, 64, 1};
        vecs[4] = '{16'h1004, 2, 8'h3C, 0, 0, 6'd4, 0, 0, 0, 64, 1};
        vecs[5] = '{16'h1004, 4, 8'h55, 0, 0, 6'd4, 1, 1, 0, 64, 1};
        vecs[6] = '{16'hBEEF, 3, 8'h81, 0, 0, 6'd1, 0, 0, 1, 0,  1};
        vecs[7] = '{16'h1234, 2, 8'h11, 0, 1, 6'd0, 0, 0, 0, 1,  1};
        vecs[8] = '{16'h2222, 1, 8'h66, 0, 1, 6'd1, 0, 0, 0, 2,  1};

        pif.data = '0; pif.key = '0; pif.sop = 1'b0; pif.eop = 1'b0; pif.vld = 1'b0;
        cfg_enable_mask = '0; cfg_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        check("rst_outputs", {mif.load_state, mif.char_in_vld, mif.eop, mif.new_stream_id,
                              err_nosop, pif.rdy}, 32'd0);
        check("rst_ids", {mif.stream_id, mif.enable, mif.char_in}, 32'd0);
        check("rst_counts", {stream_count, drop_count}, 32'd0);
        last_cyc = cyc;

        for (int i = 0; i < 3; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Fill the rest of the table with distinct single-byte packets.
        for (int i = 2; i < 64; i++) begin
            fv = '{16'h1000 + 16'(i), 1, 8'h01, 0, 1, 6'(i), 0, 0, 0, i + 1, 0};
            run_vec($sformatf("fill%0d", i), fv);
        end

        for (int i = 3; i < 9; i++) begin
            if (i == 8) begin
                push(3, 6'd0, 1'b0, 8'h00, 8'h00, -1);
                drive_beat(8'h99, 16'h0000, 1'b0, 1'b0);
                idle(4);
                check("nosop_events_left", 32'(expq.size()), 32'd0);
            end
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dpi_stream_feeder.md
Name: dpi_stream_feeder

Overview:
Packet-side driver for the per-stream regex matcher bank. It takes packets tagged with a flow key and maps each key to a 6-bit stream id through an internal 64-entry table. It then issues the load_state / new_stream_id restore request, streams payload bytes as char_in / char_in_vld, and closes each packet with a timed eop so the matchers save state and finalise counts. It sits between the packet ingress FIFO and every regex matcher instance, which all share its outputs.

Parameters:
KEY_W, 16, flow key width
SID_W, 6, stream id width; table depth NUM_STREAMS = 2**SID_W = 64
NUM_REGEX, 8, number of matcher enable bits
LOAD_GAP, 2, cycles between the load_state pulse and the first char_in_vld (matcher restore latency)
EOP_GAP, 2, cycles between the last char_in_vld and the eop pulse (matcher state_out settle)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pkt_data  in  8  payload byte
pkt_key  in  KEY_W  flow key, valid on the sop beat
pkt_sop  in  1  first beat of packet; also carries a payload byte
pkt_eop  in  1  last beat of packet
pkt_vld  in  1  beat valid
pkt_rdy  out  1  beat accepted when pkt_vld & pkt_rdy
cfg_enable_mask  in  NUM_REGEX  per-regex enable, sampled per packet
cfg_flush  in  1  clear stream table (level, honoured in IDLE)
char_in  out  8  byte to matchers
char_in_vld  out  1  char_in valid
load_state  out  1  one-cycle restore request
new_stream_id  out  1  qualifies load_state: stream unseen, restore zero state
stream_id  out  SID_W  stream under processing, stable from load_state through eop
enable  out  NUM_REGEX  per-regex enable, stable from load_state through eop
eop  out  1  one-cycle end-of-packet pulse to matchers
stream_count  out  SID_W+1  occupied table entries, 0..64
drop_count  out  16  packets dropped because the table was full; saturating
err_nosop  out  1  one-cycle pulse when a non-sop beat is discarded in IDLE

Behaviour:
- Reset values: all outputs 0; table empty; FSM in IDLE.
- Table: 64 registers {valid, key}. Lookup compares pkt_key against all valid entries in parallel, in one cycle. A hit returns the matching index.
- On a miss with stream_count < 64: allocate index = stream_count, write the key, increment stream_count, and assert new_stream_id with load_state.
- On a miss with stream_count == 64: drop the packet.
- No per-entry deletion. cfg_flush sampled in IDLE clears all valid bits and stream_count in one cycle, and the FSM stays in IDLE that cycle. A flush asserted mid-packet waits until IDLE.
- FSM states:
  - IDLE: pkt_rdy = pkt_vld & ~pkt_sop, so stray non-sop beats are discarded with an err_nosop pulse. On pkt_vld & pkt_sop, latch pkt_key (beat not consumed) and go to LOOKUP.
  - LOOKUP (1 cycle): resolve hit/miss/full. On hit or allocate, register stream_id and enable <= cfg_enable_mask, then go to LOAD. On full, go to DROP.
  - LOAD (1 cycle): load_state = 1, new_stream_id = miss. Go to GAP.
  - GAP: wait LOAD_GAP-1 further cycles, so the first char_in_vld is exactly LOAD_GAP cycles after load_state. Go to STREAM.
  - STREAM: pkt_rdy = 1. Registered outputs: char_in <= pkt_data and char_in_vld <= pkt_vld, one cycle after acceptance. Bubbles on pkt_vld pass through as char_in_vld = 0. An accepted beat with pkt_eop goes to DRAIN.
  - DRAIN: EOP_GAP cycles counted from the last char_in_vld, then go to EOP.
  - EOP (1 cycle): eop = 1, with stream_id and enable still held. Go to IDLE.
  - DROP: pkt_rdy = 1, consume beats through the pkt_eop beat, then increment drop_count (saturating at 0xFFFF) and go to IDLE. No load_state, char_in_vld or eop is issued for a dropped packet.
- Packet spacing: one packet in flight at a time. Minimum spacing from eop to the next load_state is 2 cycles (IDLE, LOOKUP).
- Single-beat packet (sop & eop on one beat): one char_in_vld, then the DRAIN/EOP sequence.
- Reset asserted mid-packet: return to IDLE immediately; table cleared; any partially consumed packet is abandoned. Upstream resets with the feeder.

Decomposition:
- Shared package dpi_pkg:
  - SID_W, KEY_W and NUM_REGEX defaults
  - FSM state enum {IDLE, LOOKUP, LOAD, GAP, STREAM, DRAIN, EOP, DROP}
  - typedef stream_entry_t {valid, key}
- One sub-module: dpi_stream_table. It holds the parallel-compare CAM with hit / hit_idx / full outputs, the allocate write port and the flush. The feeder holds the FSM, gap counters and output registers.

Test Plan:
- Fresh key 0x1234, 5-byte packet, LOAD_GAP=2, EOP_GAP=2 -> load_state with new_stream_id=1 and stream_id=0; char_in_vld exactly 2 cycles later for 5 consecutive cycles; eop 2 cycles after the last byte; stream_count=1.
- Same key 0x1234 again, then new key 0xBEEF -> first packet: load_state with new_stream_id=0, stream_id=0. Second packet: new_stream_id=1, stream_id=1, stream_count=2.
- Fill 64 distinct keys, then send a 65th key with 3 bytes -> 3 beats consumed; no load_state, char_in_vld or eop; drop_count=1. A 66th packet carrying key #5 -> stream_id=4, new_stream_id=0.
- pkt_vld toggling every other cycle during STREAM, cfg_enable_mask changed mid-packet -> char_in_vld mirrors accepted beats one cycle late; enable and stream_id stay unchanged through eop.
- cfg_flush asserted mid-packet -> current packet completes normally; flush is applied in IDLE, so stream_count=0 and the next packet (any key) gets stream_id=0 with new_stream_id=1.
- Non-sop beat while IDLE, plus a single-beat packet -> beat discarded with one err_nosop pulse; the single-beat packet produces exactly one char_in_vld, then eop EOP_GAP cycles later.
